// File: rtl/fft_sequencer_pkg.sv
// Shared constants and state encoding for the FFT sequencer, bit-reversal and butterfly units.
package fft_sequencer_pkg;

    localparam int unsigned FFT_N_POINTS = 16;
    localparam int unsigned FFT_LOG2N    = $clog2(FFT_N_POINTS);
    localparam int unsigned FFT_TIMEOUT  = 64;
    localparam int unsigned FFT_CNT_W    = 8;
    localparam int unsigned FFT_STAGE_W  = $clog2(FFT_LOG2N);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StBrGo   = 3'd1,
        StBrWait = 3'd2,
        StStGo   = 3'd3,
        StStWait = 3'd4,
        StOut    = 3'd5,
        StErr    = 3'd6
    } fft_state_e;

    // The watchdog only counts while a datapath unit owes us a done.
    function automatic logic is_wait_state(fft_state_e s);
        return (s == StBrWait) || (s == StStWait);
    endfunction

endpackage

// File: rtl/fft_watchdog.sv
// Cycle counter that flags a datapath unit which has not returned done within TIMEOUT cycles.
module fft_watchdog #(
    parameter int unsigned  TIMEOUT = 64,
    localparam int unsigned TIMER_W = $clog2(TIMEOUT)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMER_W-1:0] timer_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            timer_q <= '0;
        end else if (clear) begin
            timer_q <= '0;
        end else if (enable && !expired) begin
            timer_q <= timer_q + TIMER_W'(1);
        end
    end

    assign expired = (timer_q == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/fft_sequencer.sv
// FFT frame sequencer: accept a frame, run bit-reversal, step LOG2N butterfly stages,
// then hold the result until downstream takes it. A watchdog guards every done wait.
module fft_sequencer
    import fft_sequencer_pkg::*;
#(
    parameter int unsigned  N_POINTS = FFT_N_POINTS,
    parameter int unsigned  LOG2N    = $clog2(N_POINTS),
    parameter int unsigned  TIMEOUT  = FFT_TIMEOUT,
    parameter int unsigned  CNT_W    = FFT_CNT_W,
    localparam int unsigned STAGE_W  = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               ld_en,
    output logic               br_start,
    input  logic               br_done,
    output logic               stg_start,
    output logic [STAGE_W-1:0] stg_idx,
    input  logic               stg_done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               err_timeout,
    input  logic               err_clr,
    output logic [CNT_W-1:0]   frame_cnt
);

    fft_state_e         state_q, state_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

    logic               in_ready_q, br_start_q, stg_start_q, out_valid_q, busy_q, err_q;
    logic [STAGE_W-1:0] stg_idx_q;

    logic               wd_clear, wd_enable, wd_expired;

    fft_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    assign ld_en = in_valid & in_ready_q;

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        frame_cnt_d = frame_cnt_q;
        wd_clear    = 1'b0;
        wd_enable   = is_wait_state(state_q);

        unique case (state_q)
            StIdle: begin
                if (ld_en) begin
                    state_d = StBrGo;
                end
            end
            StBrGo: begin
                wd_clear = 1'b1;
                state_d  = StBrWait;
            end
            StBrWait: begin
                // A done arriving on the expiry cycle still counts as on time.
                if (br_done) begin
                    stage_d = '0;
                    state_d = StStGo;
                end else if (wd_expired) begin
                    state_d = StErr;
                end
            end
            StStGo: begin
                wd_clear = 1'b1;
                state_d  = StStWait;
            end
            StStWait: begin
                if (stg_done) begin
                    if (stage_q == STAGE_W'(LOG2N - 1)) begin
                        state_d = StOut;
                    end else begin
                        stage_d = stage_q + STAGE_W'(1);
                        state_d = StStGo;
                    end
                end else if (wd_expired) begin
                    state_d = StErr;
                end
            end
            StOut: begin
                if (out_ready) begin
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    state_d     = StIdle;
                end
            end
            StErr: begin
                if (err_clr) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q a cycle later.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            stage_q     <= '0;
            frame_cnt_q <= '0;
            in_ready_q  <= 1'b0;
            br_start_q  <= 1'b0;
            stg_start_q <= 1'b0;
            stg_idx_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            frame_cnt_q <= frame_cnt_d;
            in_ready_q  <= (state_d == StIdle);
            br_start_q  <= (state_d == StBrGo);
            stg_start_q <= (state_d == StStGo);
            stg_idx_q   <= (state_d == StStGo) ? stage_d : '0;
            out_valid_q <= (state_d == StOut);
            busy_q      <= (state_d != StIdle);
            err_q       <= (state_d == StErr);
        end
    end

    assign in_ready    = in_ready_q;
    assign br_start    = br_start_q;
    assign stg_start   = stg_start_q;
    assign stg_idx     = stg_idx_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
